// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for seq_alu.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Ops executed by the multi-cycle engine (when not short-circuited).
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One bit per cycle; done pulses combinationally on the last iteration and
// result is taken from that final step, so the caller can register it.
// Shared {hi,lo} register: multiply keeps partial product in hi and the
// multiplier in lo; divide keeps remainder in hi and dividend/quotient in lo.
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic             running;
    logic             div_mode;
    logic             sel_hi;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // One iteration of the selected algorithm, from the current registers.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, m};
        diff    = shifted[WIDTH-1:0] - m;
        if (div_mode) begin
            step_hi = ge ? diff : shifted[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
        done   = running && (cnt == SHW'(WIDTH - 1));
        result = sel_hi ? step_hi : step_lo;
    end

    // Operand latch on start, then one step per cycle until the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running  <= 1'b0;
            div_mode <= 1'b0;
            sel_hi   <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
        end else if (start) begin
            running  <= 1'b1;
            div_mode <= is_div(op);
            sel_hi   <= (op == OP_MULHU) || (op == OP_REMU);
            cnt      <= '0;
            hi       <= '0;
            lo       <= is_div(op) ? a : b;
            m        <= is_div(op) ? b : a;
        end else if (running) begin
            hi <= step_hi;
            lo <= step_lo;
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops, iterative mul/div, registered result/flags.
// Handshake: an op is accepted on a rising edge where InValid && InReady
// (InReady only in IDLE); a result is consumed on a rising edge where
// OutValid && OutReady, and ALUResult/ZF/SF hold steady until then.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             ZF,
    output logic             SF,
    output logic             Busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             load;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] single_res;
    logic [SHW-1:0]   shamt;

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (ALUControl),
        .a      (SrcA),
        .b      (SrcB),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle op results (illegal and iterative codes give 0 here).
    always_comb begin
        shamt      = SrcB[SHW-1:0];
        single_res = '0;
        case (ALUControl)
            OP_ADD:  single_res = SrcA + SrcB;
            OP_SUB:  single_res = SrcA - SrcB;
            OP_AND:  single_res = SrcA & SrcB;
            OP_OR:   single_res = SrcA | SrcB;
            OP_XOR:  single_res = SrcA ^ SrcB;
            OP_SLL:  single_res = SrcA << shamt;
            OP_SRL:  single_res = SrcA >> shamt;
            OP_SRA:  single_res = $signed(SrcA) >>> shamt;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            default: single_res = '0;
        endcase
    end

    // Next-state, engine start and result-load decisions.
    always_comb begin
        state_next = state;
        md_start   = 1'b0;
        load       = 1'b0;
        res_d      = '0;
        case (state)
            IDLE: begin
                if (InValid) begin
                    if (is_iterative(ALUControl)) begin
                        if (is_div(ALUControl) && (SrcB == '0)) begin
                            res_d      = (ALUControl == OP_DIVU) ? '1 : SrcA;
                            load       = 1'b1;
                            state_next = DONE;
                        end else begin
                            md_start   = 1'b1;
                            state_next = is_div(ALUControl) ? DIV : MUL;
                        end
                    end else begin
                        res_d      = single_res;
                        load       = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    res_d      = md_result;
                    load       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus result and flags, always loaded together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ALUResult <= '0;
            ZF        <= 1'b0;
            SF        <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                ALUResult <= res_d;
                ZF        <= (res_d == '0);
                SF        <= res_d[WIDTH-1];
            end
        end
    end

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);
    assign Busy     = (state == MUL) || (state == DIV);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random ops against
// an arithmetic reference model with expected latency and busy timing.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [3:0]   ALUControl;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] ALUResult;
    logic         ZF;
    logic         SF;
    logic         Busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InValid    (InValid),
        .InReady    (InReady),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .ALUResult  (ALUResult),
        .ZF         (ZF),
        .SF         (SF),
        .Busy       (Busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [63:0] prod;
        int          sh;
        longint      sa;
        longint      sb;
        sh   = int'(b % W);
        prod = 64'(a) * 64'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return W'(sa / (64'sd1 << sh) - ((sa < 0 && (sa % (64'sd1 << sh)) != 0) ? 1 : 0));
            4'd8:  return (sa < sb) ? 1 : 0;
            4'd9:  return (a < b) ? 1 : 0;
            4'd10: return prod[W-1:0];
            4'd11: return prod[63:32];
            4'd12: return (b == 0) ? {W{1'b1}} : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'd10 || op == 4'd11) return W + 1;
        if ((op == 4'd12 || op == 4'd13) && b != 0) return W + 1;
        return 1;
    endfunction

    // Driver: issue one op from IDLE, scramble inputs after accept, wait for
    // the result, hold OutReady low for `stall` cycles, then consume it.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int stall);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp;
        int           cycles;
        int           busy_cycles;
        int           exp_lat;
        logic         hold_ok;
        logic [W-1:0] res0;
        exp_q.push_back(ref_res(op, a, b));
        exp_lat = ref_latency(op, b);
        check({tag, ".in_ready"}, 64'(InReady), 64'd1);
        SrcA = a; SrcB = b; ALUControl = op; InValid = 1'b1; OutReady = 1'b0;
        @(posedge clk); #1;
        InValid = 1'b0;
        SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom_range(0, 15));
        cycles = 1;
        busy_cycles = 0;
        while (!OutValid && cycles < 100) begin
            if (Busy) busy_cycles++;
            @(posedge clk); #1;
            cycles++;
        end
        if (Busy) busy_cycles++;
        exp = exp_q.pop_front();
        check({tag, ".latency"}, 64'(cycles), 64'(exp_lat));
        check({tag, ".busy"}, 64'(busy_cycles), 64'((exp_lat == 1) ? 0 : W));
        check({tag, ".result"}, 64'(ALUResult), 64'(exp));
        check({tag, ".zf_sf"}, {62'd0, ZF, SF}, {62'd0, exp == 0, exp[W-1]});
        hold_ok = 1'b1;
        res0 = ALUResult;
        for (int i = 0; i < stall; i++) begin
            InValid = 1'b1; ALUControl = 4'($urandom_range(0, 9)); SrcA = $urandom;
            @(posedge clk); #1;
            if (ALUResult !== res0 || !OutValid || InReady || Busy ||
                ZF !== (exp == 0) || SF !== exp[W-1]) hold_ok = 1'b0;
        end
        if (stall > 0) check({tag, ".hold"}, 64'(hold_ok), 64'd1);
        // Consume; an op offered during DONE must not be taken.
        InValid = 1'b1; OutReady = 1'b1; ALUControl = 4'd0;
        @(posedge clk); #1;
        InValid = 1'b0; OutReady = 1'b0;
        check({tag, ".release"}, {62'd0, OutValid, InReady}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         quiet;
        rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        SrcA = '0; SrcB = '0; ALUControl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outs", {59'd0, OutValid, Busy, ZF, SF, InReady}, 64'd1);
        check("reset.result", 64'(ALUResult), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("sub", 4'd1, 32'd5, 32'd7, 0);
        do_op("sra", 4'd7, 32'h8000_0000, 32'd4, 0);
        do_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("mul", 4'd10, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("mulhu", 4'd11, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("divu", 4'd12, 32'd100, 32'd7, 0);
        do_op("remu", 4'd13, 32'd100, 32'd7, 0);
        do_op("divu0", 4'd12, 32'd1234, 32'd0, 0);
        do_op("remu0", 4'd13, 32'd9, 32'd0, 0);
        do_op("remu_z", 4'd13, 32'd21, 32'd7, 0);
        do_op("bp", 4'd0, 32'h1234_5678, 32'h1111_1111, 10);
        do_op("illegal", 4'd15, 32'hDEAD_BEEF, 32'd3, 0);
        do_op("sll_max", 4'd5, 32'h0000_0003, 32'h0000_003F, 0);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            do_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, $urandom_range(0, 3));
        end

        // Reset during a divide: everything clears and no result appears.
        do_op("pre_rst", 4'd0, 32'd40, 32'd2, 0);
        SrcA = 32'd100; SrcB = 32'd7; ALUControl = 4'd12; InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_div.busy", 64'(Busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.outs", {60'd0, OutValid, Busy, ZF, SF}, 64'd0);
        check("rst_mid.result", 64'(ALUResult), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (OutValid || Busy || !InReady) quiet = 1'b0;
        end
        check("post_rst.quiet", 64'(quiet), 64'd1);
        do_op("post_rst.op", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
